// File: rtl/seq_divider_if.sv
// Handshake and result bundle for seq_divider: requester drives start/operands,
// divider returns status and results.
interface seq_divider_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, results held
// until the next accepted start.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    count;
  logic             zpend;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // Shifted partial remainder is WIDTH+1 bits wide so the trial borrow is exact.
  always_comb begin
    trial  = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    rem_nx = {rem[WIDTH-2:0], quo[WIDTH-1]};
    quo_nx = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      rem             <= '0;
      quo             <= '0;
      dvs             <= '0;
      count           <= '0;
      zpend           <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A zero divisor spends one IDLE cycle with further starts blocked so
          // its result lands one edge after acceptance, without raising busy.
          if (zpend) begin
            zpend           <= 1'b0;
            state           <= DONE;
            bus.done        <= 1'b1;
            bus.quotient    <= '1;
            bus.remainder   <= quo;
            bus.div_by_zero <= 1'b1;
          end else if (bus.start) begin
            quo <= bus.dividend;
            if (bus.divisor != '0) begin
              rem      <= '0;
              dvs      <= bus.divisor;
              count    <= '0;
              state    <= CALC;
              bus.busy <= 1'b1;
            end else begin
              zpend <= 1'b1;
            end
          end
        end
        CALC: begin
          rem   <= rem_nx;
          quo   <= quo_nx;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.quotient    <= quo_nx;
            bus.remainder   <= rem_nx;
            bus.div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, handshake corner cases,
// and a randomized sweep against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;
  logic         prev_z;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic from the division rules.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = W'(int'(a) / int'(b));
      r = W'(int'(a) % int'(b));
      z = 1'b0;
    end
  endtask

  // Issues one operation and checks busy, latency, the done pulse, output holding
  // and the results. hold=1 keeps start asserted with other operands afterwards.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int lat;
    int exp_lat;
    bit seen;
    exp_lat = (b == 0) ? 1 : W;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    if (hold) begin
      bus.dividend = 8'd50;
      bus.divisor  = 8'd5;
    end else begin
      bus.start = 1'b0;
    end
    seen = 1'b0;
    lat  = 0;
    for (int j = 0; j <= W + 4; j++) begin
      if (bus.done) begin
        seen = 1'b1;
        lat  = j;
        break;
      end
      chk("busy_while_calc", 32'(bus.busy), 32'(b != 0 && j < W));
      chk("hold_quotient", 32'(bus.quotient), 32'(prev_q));
      chk("hold_remainder", 32'(bus.remainder), 32'(prev_r));
      chk("hold_dbz", 32'(bus.div_by_zero), 32'(prev_z));
      @(posedge clk); #1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_with_done", 32'(bus.busy), 32'd0);
    chk("quotient", 32'(bus.quotient), 32'(eq));
    chk("remainder", 32'(bus.remainder), 32'(er));
    chk("div_by_zero", 32'(bus.div_by_zero), 32'(ez));
    if (b != 0) begin
      chk("invariant", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
      chk("rem_lt_div", 32'(bus.remainder < b), 32'd1);
    end
    prev_q = eq;
    prev_r = er;
    prev_z = ez;
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    chk("quotient_held", 32'(bus.quotient), 32'(eq));
    bus.start = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    logic         mz;
    n_chk  = 0;
    n_fail = 0;
    prev_q = '0;
    prev_r = '0;
    prev_z = 1'b0;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   z: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0};
    vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   z: 1'b0};
    vecs[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   z: 1'b0};
    vecs[4] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,   z: 1'b0};
    vecs[5] = '{a: 8'd200, b: 8'd0,   q: 8'd255, r: 8'd200, z: 1'b1};
    vecs[6] = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,   z: 1'b0};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, 1'b0, vecs[i].q, vecs[i].r, vecs[i].z);

    // Starts during CALC and DONE must be ignored.
    run_op(8'd100, 8'd7, 1'b1, 8'd14, 8'd2, 1'b0);
    run_op(8'd50, 8'd5, 1'b0, 8'd10, 8'd0, 1'b0);

    // Reset in the fourth CALC cycle aborts the operation.
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_before_abort", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_quotient", 32'(bus.quotient), 32'd0);
    chk("abort_remainder", 32'(bus.remainder), 32'd0);
    chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    prev_q = '0;
    prev_r = '0;
    prev_z = 1'b0;
    for (int j = 0; j < W + 2; j++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", 32'(bus.done | bus.busy), 32'd0);
    end
    run_op(8'd77, 8'd8, 1'b0, 8'd9, 8'd5, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      if (i % 7 == 0) rb = W'($urandom_range(1, 3));
      model(ra, rb, mq, mr, mz);
      run_op(ra, rb, 1'b0, mq, mr, mz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
